// File: rtl/unifiedmem_pkg.sv
// Shared definitions for the unified-memory DMA block: lane count, FSM
// state and mode encodings, and the packed-bus lane indexing helper.
package unifiedmem_pkg;

    localparam int unsigned NLANES = 7;
    localparam int unsigned LANEW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_COPY = 1'b0,
        MODE_FILL = 1'b1
    } mode_e;

    // Low bit index of lane 'lane' inside a packed bus of 'width'-bit fields.
    function automatic int unsigned lane_slice(input int unsigned lane,
                                               input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/unifiedmem_lane_mux.sv
// Lane steering for the packed unified-memory bus.
//   act/lane/addr/wdata/we : the single lane access to place on the bus
//   rd_lane/mem_rd         : read-lane select and packed read data
//   mem_we_c/mem_a_c/mem_wd_c : packed bus with every other lane zero
//   rd_data_c              : selected lane slice of mem_rd
module unifiedmem_lane_mux
    import unifiedmem_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDRW = 9
) (
    input  logic                     act,
    input  logic                     we,
    input  logic [LANEW-1:0]         lane,
    input  logic [ADDRW-1:0]         addr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [LANEW-1:0]         rd_lane,
    input  logic [WIDTH*NLANES-1:0]  mem_rd,
    output logic [NLANES-1:0]        mem_we_c,
    output logic [WIDTH*NLANES-1:0]  mem_a_c,
    output logic [WIDTH*NLANES-1:0]  mem_wd_c,
    output logic [WIDTH-1:0]         rd_data_c
);

    // One active lane at most; idle lanes stay all-zero.
    always_comb begin
        mem_we_c  = '0;
        mem_a_c   = '0;
        mem_wd_c  = '0;
        rd_data_c = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (act && (lane == LANEW'(k))) begin
                mem_a_c[lane_slice(k, WIDTH) +: WIDTH]  = WIDTH'(addr);
                mem_wd_c[lane_slice(k, WIDTH) +: WIDTH] = wdata;
                mem_we_c[k]                             = we;
            end
            if (rd_lane == LANEW'(k)) begin
                rd_data_c = mem_rd[lane_slice(k, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/unifiedmem_dma.sv
// Block-transfer initiator (COPY / FILL) for the 7-lane unified memory.
//   clk, rst (async, active-high)
//   start/mode/src_lane/dst_lane/src_base/dst_base/length/fill_value : command
//   abort      : cancel an active transfer
//   busy/done/err/words_done : status
//   mem_we/mem_a/mem_wd : packed memory write/address bus (registered)
//   mem_rd     : packed combinational read data
module unifiedmem_dma
    import unifiedmem_pkg::*;
#(
    parameter  int unsigned WIDTH   = 32,
    parameter  int unsigned RAMSIZE = 512,
    localparam int unsigned ADDRW   = $clog2(RAMSIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [2:0]               src_lane,
    input  logic [2:0]               dst_lane,
    input  logic [ADDRW-1:0]         src_base,
    input  logic [ADDRW-1:0]         dst_base,
    input  logic [ADDRW:0]           length,
    input  logic [WIDTH-1:0]         fill_value,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDRW:0]           words_done,
    output logic [NLANES-1:0]        mem_we,
    output logic [WIDTH*NLANES-1:0]  mem_a,
    output logic [WIDTH*NLANES-1:0]  mem_wd,
    input  logic [WIDTH*NLANES-1:0]  mem_rd
);

    localparam int unsigned CNTW = ADDRW + 1;
    localparam int unsigned SUMW = ADDRW + 2;
    localparam int unsigned BUSW = WIDTH * NLANES;

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RD   = ST_RD;
    localparam logic [1:0] S_WR   = ST_WR;
    localparam logic [1:0] S_FIN  = ST_FIN;

    logic [1:0]        state_q,    state_n;
    logic              mode_q,     mode_n;
    logic [LANEW-1:0]  src_lane_q, src_lane_n;
    logic [LANEW-1:0]  dst_lane_q, dst_lane_n;
    logic [ADDRW-1:0]  src_base_q, src_base_n;
    logic [ADDRW-1:0]  dst_base_q, dst_base_n;
    logic [CNTW-1:0]   len_q,      len_n;
    logic [WIDTH-1:0]  fill_q,     fill_n;
    logic [CNTW-1:0]   idx_q,      idx_n;
    logic [WIDTH-1:0]  data_q,     data_n;
    logic [CNTW-1:0]   words_n;
    logic              err_n;

    logic              bus_act;
    logic              bus_we;
    logic [LANEW-1:0]  bus_lane;
    logic [ADDRW-1:0]  bus_addr;
    logic [WIDTH-1:0]  bus_wdata;

    logic [NLANES-1:0] nxt_we_c;
    logic [BUSW-1:0]   nxt_a_c;
    logic [BUSW-1:0]   nxt_wd_c;
    logic [WIDTH-1:0]  rd_data_c;

    // (base + ofs) mod RAMSIZE; base < 2^ADDRW < 2*RAMSIZE and ofs < RAMSIZE.
    function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] base,
                                                  input logic [CNTW-1:0]  ofs);
        logic [SUMW-1:0] sum;
        sum = SUMW'(base) + SUMW'(ofs);
        if (sum >= SUMW'(RAMSIZE)) sum = sum - SUMW'(RAMSIZE);
        if (sum >= SUMW'(RAMSIZE)) sum = sum - SUMW'(RAMSIZE);
        return ADDRW'(sum);
    endfunction

    // Next-state, command latch and next memory-bus request.
    always_comb begin
        state_n    = state_q;
        mode_n     = mode_q;
        src_lane_n = src_lane_q;
        dst_lane_n = dst_lane_q;
        src_base_n = src_base_q;
        dst_base_n = dst_base_q;
        len_n      = len_q;
        fill_n     = fill_q;
        idx_n      = idx_q;
        data_n     = data_q;
        words_n    = words_done;
        err_n      = 1'b0;
        bus_act    = 1'b0;
        bus_we     = 1'b0;
        bus_lane   = '0;
        bus_addr   = '0;
        bus_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_n     = mode;
                    src_lane_n = src_lane;
                    dst_lane_n = dst_lane;
                    src_base_n = src_base;
                    dst_base_n = dst_base;
                    len_n      = length;
                    fill_n     = fill_value;
                    idx_n      = '0;
                    words_n    = '0;
                    if (((mode == MODE_COPY) && (src_lane > LANEW'(NLANES - 1))) ||
                        (dst_lane > LANEW'(NLANES - 1))) begin
                        state_n = S_FIN;
                        err_n   = 1'b1;
                    end else if (length == '0) begin
                        state_n = S_FIN;
                    end else if (mode == MODE_FILL) begin
                        state_n = S_WR;
                    end else begin
                        state_n = S_RD;
                    end
                end
            end
            S_RD: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    data_n  = rd_data_c;
                    state_n = S_WR;
                end
            end
            S_WR: begin
                // The write on the bus this cycle commits even when aborting.
                idx_n   = idx_q + CNTW'(1);
                words_n = words_done + CNTW'(1);
                if (abort) begin
                    state_n = S_IDLE;
                end else if (idx_q == len_q - CNTW'(1)) begin
                    state_n = S_FIN;
                end else if (mode_q == MODE_FILL) begin
                    state_n = S_WR;
                end else begin
                    state_n = S_RD;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (state_n == S_RD) begin
            bus_act  = 1'b1;
            bus_lane = src_lane_n;
            bus_addr = wrap_add(src_base_n, idx_n);
        end else if (state_n == S_WR) begin
            bus_act   = 1'b1;
            bus_we    = 1'b1;
            bus_lane  = dst_lane_n;
            bus_addr  = wrap_add(dst_base_n, idx_n);
            bus_wdata = (mode_n == MODE_FILL) ? fill_n : data_n;
        end
    end

    unifiedmem_lane_mux #(
        .WIDTH (WIDTH),
        .ADDRW (ADDRW)
    ) u_lane_mux (
        .act       (bus_act),
        .we        (bus_we),
        .lane      (bus_lane),
        .addr      (bus_addr),
        .wdata     (bus_wdata),
        .rd_lane   (src_lane_q),
        .mem_rd    (mem_rd),
        .mem_we_c  (nxt_we_c),
        .mem_a_c   (nxt_a_c),
        .mem_wd_c  (nxt_wd_c),
        .rd_data_c (rd_data_c)
    );

    // State, command and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            src_lane_q <= '0;
            dst_lane_q <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            fill_q     <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            words_done <= '0;
            mem_we     <= '0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            state_q    <= state_n;
            mode_q     <= mode_n;
            src_lane_q <= src_lane_n;
            dst_lane_q <= dst_lane_n;
            src_base_q <= src_base_n;
            dst_base_q <= dst_base_n;
            len_q      <= len_n;
            fill_q     <= fill_n;
            idx_q      <= idx_n;
            data_q     <= data_n;
            busy       <= (state_n == S_RD) || (state_n == S_WR);
            done       <= (state_n == S_FIN);
            err        <= err_n;
            words_done <= words_n;
            mem_we     <= nxt_we_c;
            mem_a      <= nxt_a_c;
            mem_wd     <= nxt_wd_c;
        end
    end

endmodule

// File: tb/tb_unifiedmem_dma.sv
// Self-checking bench for unifiedmem_dma: a behavioural lane memory plus a
// word-level reference of every transfer (expected memory image, write
// sequence, cycle counts).
module tb_unifiedmem_dma;

    localparam int W  = 32;
    localparam int RS = 512;
    localparam int AW = 9;
    localparam int NL = 7;

    logic              clk;
    logic              rst;
    logic              start;
    logic              mode;
    logic [2:0]        src_lane;
    logic [2:0]        dst_lane;
    logic [AW-1:0]     src_base;
    logic [AW-1:0]     dst_base;
    logic [AW:0]       length;
    logic [W-1:0]      fill_value;
    logic              abort;
    logic              busy;
    logic              done;
    logic              err;
    logic [AW:0]       words_done;
    logic [NL-1:0]     mem_we;
    logic [W*NL-1:0]   mem_a;
    logic [W*NL-1:0]   mem_wd;
    logic [W*NL-1:0]   mem_rd;

    logic [W-1:0]      mem       [NL][RS];
    logic [W-1:0]      model_mem [NL][RS];
    logic              init_mem;

    int checks;
    int failures;

    unifiedmem_dma #(
        .WIDTH   (W),
        .RAMSIZE (RS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_lane   (src_lane),
        .dst_lane   (dst_lane),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .length     (length),
        .fill_value (fill_value),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_word(input int k, input int i);
        logic [31:0] kk;
        logic [31:0] ii;
        kk = 32'(k);
        ii = 32'(i);
        if (k == 0 && i >= 10 && i <= 13) return ii;
        return (kk * 32'h0100_0193) ^ (ii * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Lane memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int k = 0; k < NL; k++)
                for (int i = 0; i < RS; i++)
                    mem[k][i] <= init_word(k, i);
        end else begin
            for (int k = 0; k < NL; k++)
                if (mem_we[k]) mem[k][mem_a[W*k +: AW]] <= mem_wd[W*k +: W];
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_rd
        assign mem_rd[W*k +: W] = mem[k][mem_a[W*k +: AW]];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_memory(input string tag);
        int nbad;
        nbad = 0;
        for (int k = 0; k < NL; k++)
            for (int i = 0; i < RS; i++)
                if (mem[k][i] !== model_mem[k][i]) nbad++;
        check(tag, 256'(nbad), 256'(0));
    endtask

    // One command from the IDLE state; abort_at>0 raises abort in the cycle
    // of that write; extra pulses a conflicting start while busy.
    task automatic run_xfer(input logic m, input int sl, input int dl, input int sb,
                            input int db, input int len, input logic [W-1:0] fv,
                            input int abort_at, input logic extra);
        logic [W-1:0]    expq[$];
        logic            exp_err, aborted, got_done, got_err;
        int              exp_writes, exp_busy, busy_cnt, wr_cnt, done_cyc, abort_c, bad, budget;
        int              wd_seen, a;
        logic [W*NL-1:0] exp_a, exp_wd;

        exp_err    = (!m && sl > 6) || (dl > 6);
        exp_writes = (exp_err || len == 0) ? 0 : len;
        aborted    = (abort_at > 0) && (abort_at < exp_writes);
        if (aborted) exp_writes = abort_at;
        exp_busy   = m ? exp_writes : 2 * exp_writes;

        // Forward word-by-word transfer on the reference image.
        for (int i = 0; i < exp_writes; i++) begin
            a = (db + i) % RS;
            model_mem[dl][a] = m ? fv : model_mem[sl][(sb + i) % RS];
            expq.push_back(model_mem[dl][a]);
        end

        mode = m; src_lane = 3'(sl); dst_lane = 3'(dl);
        src_base = AW'(sb); dst_base = AW'(db); length = (AW+1)'(len);
        fill_value = fv; start = 1'b1;
        tick();
        start = 1'b0;
        src_base = AW'($urandom); dst_base = AW'($urandom);
        length = (AW+1)'($urandom); fill_value = $urandom;

        busy_cnt = 0; wr_cnt = 0; done_cyc = 0; abort_c = 0; bad = 0;
        got_done = 1'b0; got_err = 1'b0; wd_seen = -1;
        budget = 2 * len + 6;
        for (int c = 1; c <= budget; c++) begin
            abort = 1'b0;
            start = 1'b0;
            if (extra && c == 3) begin
                start = 1'b1; mode = 1'b0; src_lane = 3'd1; dst_lane = 3'd5;
                length = 10'd3;
            end
            if (busy === 1'b1) busy_cnt++;
            if (mem_we !== '0) begin
                wr_cnt++;
                exp_a  = '0;
                exp_wd = '0;
                exp_a[W*dl +: W] = W'((db + wr_cnt - 1) % RS);
                if (wr_cnt <= expq.size()) exp_wd[W*dl +: W] = expq[wr_cnt-1];
                if (mem_we !== NL'(1 << dl)) bad++;
                if (mem_a !== exp_a || mem_wd !== exp_wd) bad++;
                if (c != (m ? wr_cnt : 2 * wr_cnt)) bad++;
            end else if (busy !== 1'b1 && (mem_a !== '0 || mem_wd !== '0)) begin
                bad++;
            end
            if (done === 1'b1) begin
                got_done = 1'b1; got_err = err; wd_seen = int'(words_done); done_cyc = c;
                break;
            end
            if (aborted && abort_c != 0 && c == abort_c + 1) begin
                wd_seen = int'(words_done);
                if (busy !== 1'b0) bad++;
                break;
            end
            if (aborted && abort_c == 0 && wr_cnt == abort_at) begin
                abort = 1'b1;
                abort_c = c;
            end
            tick();
        end
        abort = 1'b0;
        start = 1'b0;

        check("done_seen",   256'(got_done), 256'(!aborted));
        check("err_flag",    256'(got_err),  256'(exp_err && !aborted));
        check("done_cycle",  256'(done_cyc), 256'(aborted ? 0 : exp_busy + 1));
        check("busy_cycles", 256'(busy_cnt), 256'(exp_busy));
        check("write_count", 256'(wr_cnt),   256'(exp_writes));
        check("words_done",  256'(wd_seen),  256'(exp_writes));
        check("write_seq",   256'(bad),      256'(0));
        if (got_done) begin
            tick();
            check("done_pulse", 256'({done, err}), 256'(0));
        end
        compare_memory("memory");
    endtask

    initial begin
        int m, sl, dl, sb, db, len, ab;
        checks = 0; failures = 0;
        rst = 1'b0; init_mem = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
        src_lane = '0; dst_lane = '0; src_base = '0; dst_base = '0;
        length = '0; fill_value = '0;
        for (int k = 0; k < NL; k++)
            for (int i = 0; i < RS; i++)
                model_mem[k][i] = init_word(k, i);
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_busy",       256'(busy),       256'(0));
        check("rst_done_err",   256'({done, err}), 256'(0));
        check("rst_words_done", 256'(words_done), 256'(0));
        check("rst_mem_we",     256'(mem_we),     256'(0));
        check("rst_mem_a",      256'(mem_a),      256'(0));
        check("rst_mem_wd",     256'(mem_wd),     256'(0));
        init_mem = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();

        // Directed: basic copy, wrapping fill, rejected lanes, empty command.
        run_xfer(1'b0, 0, 3, 10, 100, 4, 32'h0, 0, 1'b0);
        check("copy_dst100", 256'(mem[3][100]), 256'(32'hA));
        check("copy_dst103", 256'(mem[3][103]), 256'(32'hD));
        run_xfer(1'b1, 0, 6, 0, 510, 4, 32'hDEADBEEF, 0, 1'b0);
        check("fill_wrap0", 256'(mem[6][0]), 256'(32'hDEADBEEF));
        run_xfer(1'b0, 0, 7, 0, 0, 4, 32'h0, 0, 1'b0);
        run_xfer(1'b0, 7, 2, 0, 0, 4, 32'h0, 0, 1'b0);
        run_xfer(1'b1, 7, 2, 0, 40, 3, 32'h1234_5678, 0, 1'b0);
        run_xfer(1'b0, 1, 2, 5, 6, 0, 32'h0, 0, 1'b0);

        // Abort in the second write, then an immediate new command.
        run_xfer(1'b0, 2, 4, 300, 200, 8, 32'h0, 2, 1'b0);
        run_xfer(1'b0, 4, 1, 200, 50, 3, 32'h0, 0, 1'b0);
        run_xfer(1'b1, 0, 0, 0, 70, 6, 32'hCAFE_0001, 3, 1'b0);

        // Overlapping same-lane copy, whole-lane fill, start while busy.
        run_xfer(1'b0, 1, 1, 20, 22, 6, 32'h0, 0, 1'b0);
        run_xfer(1'b0, 2, 2, 508, 2, 7, 32'h0, 0, 1'b0);
        run_xfer(1'b1, 0, 5, 0, 123, RS, 32'h0BAD_F00D, 0, 1'b0);
        run_xfer(1'b1, 0, 2, 0, 90, 6, 32'h7777_1111, 0, 1'b1);

        // Asynchronous reset in the middle of a fill.
        mode = 1'b1; dst_lane = 3'd4; dst_base = '0; length = 10'd20;
        fill_value = 32'hFEED_FACE; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_fill_busy", 256'(busy), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_busy",  256'({busy, done, err}), 256'(0));
        check("arst_words", 256'(words_done), 256'(0));
        check("arst_we",    256'(mem_we), 256'(0));
        check("arst_a",     256'(mem_a),  256'(0));
        check("arst_wd",    256'(mem_wd), 256'(0));
        @(negedge clk) rst = 1'b0;
        tick();
        for (int k = 0; k < NL; k++)
            for (int i = 0; i < RS; i++)
                model_mem[k][i] = mem[k][i];
        run_xfer(1'b0, 4, 3, 0, 400, 5, 32'h0, 0, 1'b0);

        // Randomized commands.
        for (int t = 0; t < 24; t++) begin
            m  = int'($urandom_range(0, 1));
            sl = int'($urandom_range(0, 6));
            dl = int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) dl = sl;
            sb  = int'($urandom_range(0, RS - 1));
            db  = int'($urandom_range(0, RS - 1));
            len = int'($urandom_range(1, 24));
            if ($urandom_range(0, 7) == 0) len = 0;
            if ($urandom_range(0, 9) == 0) dl = 7;
            ab = 0;
            if (len > 1 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(1, len - 1));
            run_xfer(1'(m), sl, dl, sb, db, len, $urandom, ab, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
